// File: rtl/mul_unit_if.sv
// Request/response bundle between the multiply decode (master) and mul_unit (slave).
// stall is the only combinational signal in the bundle.
interface mul_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;

    modport master (
        output start, op, a, b,
        input  busy, stall, done, result_lo, result_hi, flags
    );

    modport slave (
        input  start, op, a, b,
        output busy, stall, done, result_lo, result_hi, flags
    );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier: MUL / UMULL / SMULL with N,Z flags.
// One bit of the multiplier per RUN cycle, then a sign-fix cycle, then a done pulse.
module mul_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mul_unit_if.slave  bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [3:0]       flags_q, flags_d;

    logic             req_smull;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prod;

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;

        req_smull = (bus.op == 2'b11);
        a_mag     = (req_smull && bus.a[WIDTH-1]) ? WIDTH'(-bus.a) : bus.a;
        b_mag     = (req_smull && bus.b[WIDTH-1]) ? WIDTH'(-bus.b) : bus.b;
        sum       = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
        prod      = neg_q ? PW'(-acc_q) : acc_q;

        unique case (state_q)
            S_IDLE: begin
                // done_q blocks a held start from retriggering in the done cycle
                if (bus.start && !done_q) begin
                    op_d     = bus.op;
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = req_smull & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_lo_d = prod[WIDTH-1:0];
                if (op_q[1]) begin
                    res_hi_d = prod[PW-1:WIDTH];
                    flags_d  = {prod[PW-1], (prod == '0), 2'b00};
                end else begin
                    res_hi_d = '0;
                    flags_d  = {prod[WIDTH-1], (prod[WIDTH-1:0] == '0), 2'b00};
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
    assign bus.flags     = flags_q;
    assign bus.stall     = busy_q | (bus.start & ~done_q);

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: vector table of products/flags plus handshake,
// held-start and mid-operation reset sequences.
module tb_mul_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_unit_if #(.WIDTH(32)) bus ();
    mul_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  fl;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one multiply, scramble inputs while busy, wait for done (bounded).
    task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] lo, output logic [31:0] hi,
                           output logic [3:0] fl);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        #1;
        check("stall_cycle0", 64'(bus.stall), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
        lat = 0; lo = '0; hi = '0; fl = '0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.done) begin
                lat = k; lo = bus.result_lo; hi = bus.result_hi; fl = bus.flags;
                break;
            end
            @(negedge clk);
        end
    endtask

    int          lat;
    logic [31:0] lo, hi;
    logic [3:0]  fl;
    int          dones;

    initial begin
        vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         32'h0,          4'b0000};
        vecs[1]  = '{2'b00, 32'h0001_0000,  32'h0001_0000,  32'h0,          32'h0,          4'b0100};
        vecs[2]  = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE,  4'b1000};
        vecs[3]  = '{2'b11, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  32'hFFFF_FFFF,  4'b1000};
        vecs[4]  = '{2'b11, 32'h8000_0000,  32'h8000_0000,  32'h0,          32'h4000_0000,  4'b0000};
        vecs[5]  = '{2'b01, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'h0,          4'b1000};
        vecs[6]  = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h1,          32'h0,          4'b0000};
        vecs[7]  = '{2'b10, 32'd0,          32'd12345,      32'h0,          32'h0,          4'b0100};
        vecs[8]  = '{2'b11, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'hFFFF_FFFF,  4'b1000};
        vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          4'b1000};
        vecs[10] = '{2'b11, 32'd0,          32'hFFFF_FFFB,  32'h0,          32'h0,          4'b0100};
        vecs[11] = '{2'b10, 32'h1234_5678,  32'h10,         32'h2345_6780,  32'h1,          4'b0000};

        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d_busy", c),  64'(bus.busy),      64'd0);
            check($sformatf("idle%0d_done", c),  64'(bus.done),      64'd0);
            check($sformatf("idle%0d_stall", c), 64'(bus.stall),     64'd0);
            check($sformatf("idle%0d_res", c),   {bus.result_hi, bus.result_lo}, 64'd0);
            check($sformatf("idle%0d_flags", c), 64'(bus.flags),     64'd0);
        end

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            run_mul(vecs[i].op, vecs[i].a, vecs[i].b, lat, lo, hi, fl);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("v%0d_lo", i),      64'(lo),  64'(vecs[i].lo));
            check($sformatf("v%0d_hi", i),      64'(hi),  64'(vecs[i].hi));
            check($sformatf("v%0d_flags", i),   64'(fl),  64'(vecs[i].fl));
            @(negedge clk);
            check($sformatf("v%0d_done_clr", i), 64'(bus.done),      64'd0);
            check($sformatf("v%0d_lo_hold", i),  64'(bus.result_lo), 64'(vecs[i].lo));
        end

        // Held start: one done in 40 cycles, operands changed at cycle 10 unused
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd3; bus.b = 32'd5;
        dones = 0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (k == 10) begin bus.a = 32'd9; bus.b = 32'd9; end
            if (bus.done) begin
                dones++;
                check("hold_done_cycle", 64'(k), 64'd34);
                check("hold_lo", 64'(bus.result_lo), 64'd15);
                check("hold_hi", 64'(bus.result_hi), 64'd0);
            end
            if (k == 34) begin
                check("hold_busy34",  64'(bus.busy),  64'd0);
                check("hold_stall34", 64'(bus.stall), 64'd0);
            end
            if (k == 35) check("hold_stall35", 64'(bus.stall), 64'd1);
            if (k == 36) check("hold_busy36",  64'(bus.busy),  64'd1);
        end
        check("hold_done_count", 64'(dones), 64'd1);
        bus.start = 1'b0;
        // Second multiply accepted in cycle 35 with operands 9*9; done at cycle 69
        lat = 0;
        for (int k = 40; k <= 100; k++) begin
            @(negedge clk);
            if (bus.done) begin lat = k; break; end
        end
        check("hold2_done_cycle", 64'(lat), 64'd69);
        check("hold2_lo", 64'(bus.result_lo), 64'd81);

        // Reset mid-UMULL
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k < 15; k++) @(negedge clk);
        check("mid_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy",  64'(bus.busy),  64'd0);
        check("rst_done",  64'(bus.done),  64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_res",   {bus.result_hi, bus.result_lo}, 64'd0);
        check("rst_flags", 64'(bus.flags), 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("rst_no_done", 64'(dones), 64'd0);

        run_mul(2'b10, 32'hFFFF_FFFF, 32'd2, lat, lo, hi, fl);
        check("post_rst_latency", 64'(lat), 64'd34);
        check("post_rst_prod", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        check("post_rst_flags", 64'(fl), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative 32x32 multiplier that sits directly downstream of the controller's multiply decode. It consumes the multiply request (start plus operation select) and the two register operands. It produces a 32- or 64-bit product with N/Z flags after a fixed multi-cycle latency. While a multiply is in flight it raises a stall so the datapath holds PC and the current instruction.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. All values below assume 32.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high
- start  input  1  multiply request (decoded multiply instruction whose condition passed)
- op  input  2  00 MUL (32-bit), 01 MUL (alias), 10 UMULL, 11 SMULL
- a  input  32  multiplicand (Rn)
- b  input  32  multiplier (Rm)
- busy  output  1  high when state is not IDLE
- stall  output  1  combinational: busy | (start & ~done)
- done  output  1  one-cycle pulse; result valid
- result_lo  output  32  product bits [31:0]
- result_hi  output  32  product bits [63:32]; 0 for MUL
- flags  output  4  {N, Z, 0, 0}; C and V always 0, and the flag-write path preserves them

## Operation
- States: IDLE, RUN, FIX.
- IDLE: start accepted when start=1 and done=0. On acceptance:
  - latch op;
  - latch |a| and |b| for SMULL (two's-complement magnitude), or a and b unchanged otherwise;
  - latch neg = a[31]^b[31] for SMULL, 0 otherwise;
  - clear 64-bit accumulator and 6-bit count;
  - go to RUN.
- RUN: each cycle, if multiplier LSB=1, add multiplicand into the accumulator upper half with carry-out. Shift {carry, accumulator} right by 1, shift the multiplier right by 1, and increment count. After the cycle where count=31, go to FIX.
- FIX:
  - Product P = neg ? -acc : acc, as a 64-bit two's complement.
  - MUL: result_lo=P[31:0], result_hi=0, N=P[31], Z=(P[31:0]==0).
  - UMULL/SMULL: result_lo=P[31:0], result_hi=P[63:32], N=P[63], Z=(P==0).
  - Register the results, set done=1, go to IDLE.
- done: high exactly one cycle, the cycle after FIX. Cleared on the next edge.
- result_lo, result_hi and flags hold their values until the next FIX or reset.
- Operand or op changes while busy have no effect.
- start while busy is ignored. start during the done cycle is ignored, so a held instruction does not retrigger.
- Width rules: the unsigned accumulator add is 33-bit, with the carry shifted in. SMULL magnitudes are unsigned 32-bit, so -2^31 maps to 0x80000000 exactly.
- Reset values: state=IDLE, busy=0, done=0, result_lo=0, result_hi=0, flags=0, count=0.
- Reset mid-operation: abort immediately. No done pulse is produced, and outputs return to their reset values.

## Timing
- Cycle 0: start=1 in IDLE, so stall=1 combinationally and the request is sampled at the end of cycle 0.
- Cycles 1-32: RUN, busy=1, stall=1.
- Cycle 33: FIX, busy=1.
- Cycle 34: done=1, busy=0, stall=0, results valid. The datapath writes back and advances PC.
- Latency from the start edge to done is 34 cycles. Throughput is one multiply per 35 cycles.
- A new start is accepted no earlier than cycle 35.
- stall depends combinationally on start and done, with no path from result outputs. It must not combine with outputs to form a loop.

## Test plan
- Reset then idle: hold reset 2 cycles, then start=0 for 5 cycles -> busy=0, done=0, stall=0, results=0, flags=0.
- MUL: op=00, a=7, b=6 -> done in cycle 34 with result_lo=42, result_hi=0, flags=0000. Also a=0x10000, b=0x10000 -> result_lo=0, flags=0100 (Z).
- UMULL: op=10, a=0xFFFFFFFF, b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, flags=1000.
- SMULL signs: a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, N=1. Then a=b=0x80000000 -> hi=0x40000000, lo=0, flags=0000.
- Handshake: hold start=1 with the same op for 40 cycles -> exactly one done, at cycle 34. The second multiply is accepted in cycle 35. Operands changed in cycle 10 do not alter the result.
- Reset mid-op: assert reset in cycle 15 of a UMULL -> next cycle busy=0, outputs 0, no done pulse. A fresh start afterwards completes normally in 34 cycles.
